// File: rtl/jump_ctrl_bht.sv
// Next-PC / flush control with a per-entry saturating-counter branch history table.
// Define JUMP_CTRL_BHT_STATS_EN to add branch_cnt / mispred_cnt statistics outputs.
module jump_ctrl_bht #(
  parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8,
  parameter int          BHT_DEPTH   = 16,
  parameter int          CNT_W       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ID_branch_taken,
  input  logic [31:0] PC,
  input  logic [31:0] INS,
  input  logic [31:0] jr_addr,
  output logic [31:0] NPC,
  output logic        clr
`ifdef JUMP_CTRL_BHT_STATS_EN
  ,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic up);
    if (up) return (c == CNT_MAX) ? c : c + 1'b1;
    else    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic [CNT_W-1:0]  bht [BHT_DEPTH];

  logic [5:0]        op_p0, funct_p0;
  logic [4:0]        rt_p0, rd_p0, shamt_p0;
  logic              is_br_p0, is_jr_p0, is_j_p0, pred_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [31:0]       pc4_p0, tgt_p0;
  logic signed [31:0] off_p0;

  logic              br_vld_p1, jr_vld_p1, pred_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic [31:0]       tgt_p1, pc4_p1;
  logic              mispred;

  // IF stage: decode, lookup and target computation
  always_comb begin
    op_p0    = INS[31:26];
    rt_p0    = INS[20:16];
    rd_p0    = INS[15:11];
    shamt_p0 = INS[10:6];
    funct_p0 = INS[5:0];
    is_br_p0 = ((op_p0 == 6'd1) && (rt_p0 == 5'd0 || rt_p0 == 5'd1)) ||
               ((op_p0 == 6'd6 || op_p0 == 6'd7) && (rt_p0 == 5'd0)) ||
               (op_p0 == 6'd4) || (op_p0 == 6'd5);
    is_jr_p0 = (op_p0 == 6'd0) && (rt_p0 == 5'd0) && (shamt_p0 == 5'd0) &&
               ((funct_p0 == 6'd9) || (funct_p0 == 6'd8 && rd_p0 == 5'd0));
    is_j_p0  = (op_p0 == 6'd2) || (op_p0 == 6'd3);
    idx_p0   = PC[IDX_W+1:2];
    pred_p0  = bht[idx_p0][CNT_W-1];
    pc4_p0   = (PC < MAX_INSADDR) ? PC + 32'd4 : PC;
    off_p0   = {{14{INS[15]}}, INS[15:0], 2'b00};
    tgt_p0   = pc4_p0 + $unsigned(off_p0);
  end

  // ID stage resolution and next-PC priority
  always_comb begin
    mispred = br_vld_p1 && (ID_branch_taken != pred_p1);
    clr     = 1'b0;
    NPC     = pc4_p0;
    if (mispred) begin
      clr = 1'b1;
      NPC = ID_branch_taken ? tgt_p1 : pc4_p1;
    end else if (jr_vld_p1) begin
      clr = 1'b1;
      NPC = jr_addr;
    end else if (is_br_p0) begin
      NPC = pred_p0 ? tgt_p0 : pc4_p0;
    end else if (is_j_p0) begin
      NPC = {PC[31:28], INS[25:0], 2'b00};
    end
  end

  // IF -> ID register; a flush squashes the fetched instruction's flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_vld_p1 <= 1'b0;
      jr_vld_p1 <= 1'b0;
      pred_p1   <= 1'b0;
      idx_p1    <= '0;
      tgt_p1    <= '0;
      pc4_p1    <= '0;
    end else if (!stall) begin
      br_vld_p1 <= is_br_p0 && !clr;
      jr_vld_p1 <= is_jr_p0 && !clr;
      pred_p1   <= pred_p0;
      idx_p1    <= idx_p0;
      tgt_p1    <= tgt_p0;
      pc4_p1    <= pc4_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
    end else if (!stall && br_vld_p1) begin
      bht[idx_p1] <= sat_step(bht[idx_p1], ID_branch_taken);
    end
  end

`ifdef JUMP_CTRL_BHT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (!stall && br_vld_p1) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (mispred) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jump_ctrl_bht.sv
// Bench for jump_ctrl_bht: directed vector table, reset corner sequence, randomized model check.
module tb_jump_ctrl_bht;
  localparam logic [31:0] MAX   = 32'hffff_fff8;
  localparam int          DEPTH = 16;
  localparam int          CW    = 2;

  localparam logic [31:0] BEQ = 32'h1000_0004;
  localparam logic [31:0] BNE = 32'h1400_fffe;
  localparam logic [31:0] JR  = 32'h03e0_0008;
  localparam logic [31:0] JMP = 32'h0800_0040;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, taken, clr;
  logic [31:0] pc, ins, jra, npc;
`ifdef JUMP_CTRL_BHT_STATS_EN
  logic [31:0] bcnt, mcnt;
`endif

  always #5 clk = ~clk;

  jump_ctrl_bht #(.MAX_INSADDR(MAX), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ID_branch_taken(taken),
    .PC(pc), .INS(ins), .jr_addr(jra), .NPC(npc), .clr(clr)
`ifdef JUMP_CTRL_BHT_STATS_EN
    , .branch_cnt(bcnt), .mispred_cnt(mcnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        taken;
    logic        stall;
    logic [31:0] jra;
    logic [31:0] enpc;
    logic        eclr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [31:0] p, input logic [31:0] w, input logic t,
                              input logic s, input logic [31:0] j, input logic [31:0] en,
                              input logic ec);
    vec_t v;
    v.pc = p; v.ins = w; v.taken = t; v.stall = s; v.jra = j; v.enpc = en; v.eclr = ec;
    tbl.push_back(v);
  endfunction

  // reference model state
  int          mc [DEPTH];
  bit          mbr, mjr, mpred;
  int          midx;
  logic [31:0] mtgt, mpc4;
  logic [31:0] mbc, mmc;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mc[i] = (1 << (CW - 1)) - 1;
    mbr = 0; mjr = 0; mpred = 0; midx = 0; mtgt = 0; mpc4 = 0; mbc = 0; mmc = 0;
  endfunction

  // 0 other, 1 conditional branch, 2 register jump, 3 absolute jump
  function automatic int kind_of(input logic [31:0] w);
    int op, rt, rd, sh, fn;
    op = int'(w >> 26);
    rt = int'((w >> 16) & 32'h1f);
    rd = int'((w >> 11) & 32'h1f);
    sh = int'((w >> 6) & 32'h1f);
    fn = int'(w & 32'h3f);
    if (op == 4 || op == 5) return 1;
    if (op == 1 && rt <= 1) return 1;
    if ((op == 6 || op == 7) && rt == 0) return 1;
    if (op == 0 && rt == 0 && sh == 0 && (fn == 9 || (fn == 8 && rd == 0))) return 2;
    if (op == 2 || op == 3) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {6'(4 + $urandom_range(0, 1)), r[25:0]};
      1: return {6'd1, r[25:21], 5'($urandom_range(0, 2)), r[15:0]};
      2: return {6'(6 + $urandom_range(0, 1)), r[25:21], ($urandom_range(0, 3) == 0) ? r[20:16] : 5'd0, r[15:0]};
      3: return {6'd0, r[25:21], 5'd0, ($urandom_range(0, 1) == 0) ? 5'd0 : r[15:11],
                 ($urandom_range(0, 5) == 0) ? r[10:6] : 5'd0, 6'(8 + $urandom_range(0, 1))};
      4: return {6'(2 + $urandom_range(0, 1)), r[25:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, e_idx, off;
    bit          e_pred, miss;
    logic [31:0] e_pc4, e_tgt, enpc;
    logic        eclr;

    rst = 1'b1; stall = 1'b0; taken = 1'b0; pc = 32'h0; ins = NOP; jra = 32'h0;
    #2;
    chk("reset_clr", {31'd0, clr}, 32'd0);
    chk("reset_npc", npc, 32'h4);
`ifdef JUMP_CTRL_BHT_STATS_EN
    chk("reset_branch_cnt", bcnt, 32'd0);
    chk("reset_mispred_cnt", mcnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    add(32'h100, BEQ, 0, 0, 0, 32'h104, 0);
    add(32'h104, NOP, 1, 0, 0, 32'h114, 1);
    add(32'h100, BEQ, 0, 0, 0, 32'h114, 0);
    add(32'h114, NOP, 1, 0, 0, 32'h118, 0);
    add(32'h100, BEQ, 0, 0, 0, 32'h114, 0);
    add(32'h114, NOP, 0, 0, 0, 32'h104, 1);
    add(32'h100, BEQ, 0, 0, 0, 32'h114, 0);
    add(32'h114, NOP, 1, 0, 0, 32'h118, 0);
    add(32'h200, JR,  0, 0, 0, 32'h204, 0);
    add(32'h204, BEQ, 0, 0, 32'h2000, 32'h2000, 1);
    add(32'h2000, NOP, 1, 0, 0, 32'h2004, 0);
    add(32'h3000, JMP, 0, 0, 0, 32'h100, 0);
    add(32'h100, BNE, 0, 0, 0, 32'hfc, 0);
    add(32'hfc, NOP, 0, 1, 0, 32'h104, 1);
    add(32'hfc, NOP, 0, 1, 0, 32'h104, 1);
    add(32'hfc, NOP, 0, 1, 0, 32'h104, 1);
    add(32'hfc, NOP, 0, 0, 0, 32'h104, 1);
    add(32'h100, BNE, 0, 0, 0, 32'hfc, 0);
    add(32'hffff_fffc, NOP, 1, 0, 0, 32'hffff_fffc, 0);
    add(32'hffff_fff4, NOP, 0, 0, 0, 32'hffff_fff8, 0);
    add(32'hffff_fff0, BEQ, 0, 0, 0, 32'hffff_fff4, 0);
    add(32'h0, NOP, 1, 0, 0, 32'h4, 1);
    add(32'h140, BEQ, 0, 0, 0, 32'h154, 0);
    add(32'h154, NOP, 0, 0, 0, 32'h144, 1);
    add(32'h140, BEQ, 0, 0, 0, 32'h154, 0);
    add(32'h154, NOP, 0, 0, 0, 32'h144, 1);
    add(32'h100, BEQ, 0, 0, 0, 32'h104, 0);
    add(32'h104, NOP, 1, 0, 0, 32'h114, 1);
    add(32'h140, BEQ, 0, 0, 0, 32'h154, 0);
    add(32'h154, NOP, 0, 0, 0, 32'h144, 1);

    foreach (tbl[i]) begin
      pc = tbl[i].pc; ins = tbl[i].ins; taken = tbl[i].taken;
      stall = tbl[i].stall; jra = tbl[i].jra;
      #2;
      chk($sformatf("vec%0d_npc", i), npc, tbl[i].enpc);
      chk($sformatf("vec%0d_clr", i), {31'd0, clr}, {31'd0, tbl[i].eclr});
      @(posedge clk);
      #1;
    end

    // async reset while a mispredicted branch waits in ID
    stall = 1'b0; pc = 32'h100; ins = BEQ; taken = 1'b0;
    #2 chk("rstseq_fetch_npc", npc, 32'h104);
    @(posedge clk);
    #1 pc = 32'h104; ins = NOP; taken = 1'b1;
    #2 chk("rstseq_pending_clr", {31'd0, clr}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstseq_async_clr", {31'd0, clr}, 32'd0);
    chk("rstseq_async_npc", npc, 32'h108);
`ifdef JUMP_CTRL_BHT_STATS_EN
    chk("rstseq_branch_cnt", bcnt, 32'd0);
    chk("rstseq_mispred_cnt", mcnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0; taken = 1'b0; pc = 32'hffff_fff0; ins = BEQ;
    #2 chk("rstseq_cnt12_npc", npc, 32'hffff_fff4);
    pc = 32'h100;
    #1 chk("rstseq_cnt0_npc", npc, 32'h104);
    @(posedge clk);

    // randomized run against the model
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 800; n++) begin
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 4) == 0);
      taken = $urandom_range(0, 1);
      jra   = $urandom;
      ins   = rand_ins();
      if ($urandom_range(0, 7) == 0) pc = 32'hffff_ffc0 + 32'($urandom_range(0, 15) * 4);
      else                           pc = 32'h100 + 32'($urandom_range(0, 63) * 4);
      if (rst) model_reset();

      kind   = kind_of(ins);
      e_pc4  = (pc < MAX) ? pc + 32'd4 : pc;
      off    = int'($signed(ins[15:0]));
      e_tgt  = e_pc4 + 32'(off * 4);
      e_idx  = int'((pc >> 2) % DEPTH);
      e_pred = (mc[e_idx] >= (1 << (CW - 1)));
      miss   = mbr && (taken != mpred);
      if (miss) begin
        enpc = taken ? mtgt : mpc4; eclr = 1'b1;
      end else if (mjr) begin
        enpc = jra; eclr = 1'b1;
      end else begin
        eclr = 1'b0;
        if (kind == 1)      enpc = e_pred ? e_tgt : e_pc4;
        else if (kind == 3) enpc = {pc[31:28], ins[25:0], 2'b00};
        else                enpc = e_pc4;
      end

      #2;
      chk($sformatf("rnd%0d_npc", n), npc, enpc);
      chk($sformatf("rnd%0d_clr", n), {31'd0, clr}, {31'd0, eclr});
`ifdef JUMP_CTRL_BHT_STATS_EN
      chk($sformatf("rnd%0d_branch_cnt", n), bcnt, mbc);
      chk($sformatf("rnd%0d_mispred_cnt", n), mcnt, mmc);
`endif
      @(posedge clk);
      if (!stall && !rst) begin
        if (mbr) begin
          mbc = mbc + 32'd1;
          if (miss) mmc = mmc + 32'd1;
          if (taken) mc[midx] = (mc[midx] == (1 << CW) - 1) ? mc[midx] : mc[midx] + 1;
          else       mc[midx] = (mc[midx] == 0) ? 0 : mc[midx] - 1;
        end
        mbr   = (kind == 1) && !eclr;
        mjr   = (kind == 2) && !eclr;
        midx  = e_idx;
        mpred = e_pred;
        mtgt  = e_tgt;
        mpc4  = e_pc4;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
